// File: rtl/dec_scan_n.sv
// N-to-2^N one-hot decoder with registered outputs and an auto-scan mode that
// rotates the active line with a programmable dwell time per line.
module dec_scan_n #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         i,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 load,
  output logic [(1<<N)-1:0]    q,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int W = 1 << N;

  localparam logic [N-1:0]       IDX_ONE  = N'(1'b1);
  localparam logic [N-1:0]       IDX_LAST = {N{1'b1}};
  localparam logic [W-1:0]       Q_ONE    = W'(1'b1);
  localparam logic [W-1:0]       Q_ZERO   = {W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1'b1);
  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         q_q, q_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    return Q_ONE << sel;
  endfunction

  // Next-state and next-output decode for idle, direct and scan operation.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      q_d     = Q_ZERO;
      cnt_d   = CNT_ZERO;
    end else if (!mode) begin
      state_d = ST_DIRECT;
      q_d     = onehot(i);
      idx_d   = i;
      cnt_d   = CNT_ZERO;
    end else begin
      state_d = ST_SCAN;
      case (state_q)
        ST_SCAN: begin
          // load wins over an advance falling due on the same edge
          if (load) begin
            q_d   = onehot(i);
            idx_d = i;
            cnt_d = CNT_ZERO;
          end else if (cnt_q >= dwell) begin
            q_d    = {q_q[W-2:0], q_q[W-1]};
            idx_d  = idx_q + IDX_ONE;
            cnt_d  = CNT_ZERO;
            wrap_d = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          q_d   = onehot(i);
          idx_d = i;
          cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= Q_ZERO;
      idx_q   <= {N{1'b0}};
      cnt_q   <= CNT_ZERO;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
